// File: rtl/prediction_stabilizer_if.sv
// Prediction-in / published-digit-out bundle for prediction_stabilizer.
// Handshake: pred_valid is a one-cycle strobe with no ready/backpressure. predicted_digit is sampled only on edges where pred_valid=1.
interface prediction_stabilizer_if;
  logic       pred_valid;
  logic [3:0] predicted_digit;
  logic [3:0] digit_out;
  logic       digit_valid;
  logic       update_pulse;
  logic       reject_pulse;
  logic       fsm_state;

  modport master (
    output pred_valid, predicted_digit,
    input  digit_out, digit_valid, update_pulse, reject_pulse, fsm_state
  );

  modport slave (
    input  pred_valid, predicted_digit,
    output digit_out, digit_valid, update_pulse, reject_pulse, fsm_state
  );
endinterface

// File: rtl/prediction_stabilizer.sv
// Publishes a digit after STABLE_COUNT identical predictions and withdraws it after TIMEOUT_CYCLES idle cycles.
// Optional SEVEN_SEG_EN adds a registered active-low seven-segment output (seg_n).
module prediction_stabilizer #(
  parameter int STABLE_COUNT   = 3,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int CNT_W          = 26
) (
  input  logic                    clk,
  input  logic                    rst_n,
  prediction_stabilizer_if.slave  bus
`ifdef SEVEN_SEG_EN
  ,
  output logic [6:0]              seg_n
`endif
);

  typedef enum logic {EMPTY = 1'b0, SHOWN = 1'b1} state_t;

  localparam logic [3:0]       STABLE   = 4'(STABLE_COUNT);
  localparam bit               TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = TMO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t           state;
  logic [3:0]       run_digit;
  logic [3:0]       run_cnt;
  logic [CNT_W-1:0] tmo_cnt;
  logic [3:0]       digit_out;
  logic             digit_valid;
  logic             update_pulse;
  logic             reject_pulse;

  logic [3:0] new_digit;
  logic [3:0] new_cnt;
  logic       reject;
  logic       publish;
  logic       timeout;

  always_comb begin
    new_digit = run_digit;
    new_cnt   = run_cnt;
    reject    = 1'b0;
    if (bus.pred_valid) begin
      if (bus.predicted_digit > 4'd9) begin
        new_cnt = 4'd0;
        reject  = 1'b1;
      end else if (run_cnt != 4'd0 && bus.predicted_digit == run_digit) begin
        new_cnt = (run_cnt >= STABLE) ? STABLE : run_cnt + 4'd1;
      end else begin
        new_digit = bus.predicted_digit;
        new_cnt   = 4'd1;
      end
    end
    publish = bus.pred_valid && !reject && new_cnt == STABLE &&
              (state == EMPTY || new_digit != digit_out);
    // A strobe on the expiry edge keeps the display alive.
    timeout = TMO_EN && state == SHOWN && !bus.pred_valid && tmo_cnt == TMO_LAST;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= EMPTY;
      run_digit    <= 4'd0;
      run_cnt      <= 4'd0;
      tmo_cnt      <= '0;
      digit_out    <= 4'd0;
      digit_valid  <= 1'b0;
      update_pulse <= 1'b0;
      reject_pulse <= 1'b0;
    end else begin
      update_pulse <= publish;
      reject_pulse <= reject;
      if (timeout) begin
        state       <= EMPTY;
        digit_valid <= 1'b0;
        run_cnt     <= 4'd0;
        tmo_cnt     <= '0;
      end else begin
        run_digit <= new_digit;
        run_cnt   <= new_cnt;
        if (bus.pred_valid)
          tmo_cnt <= '0;
        else if (TMO_EN && state == SHOWN)
          tmo_cnt <= tmo_cnt + CNT_W'(1);
        if (publish) begin
          state       <= SHOWN;
          digit_out   <= new_digit;
          digit_valid <= 1'b1;
        end
      end
    end
  end

  assign bus.digit_out    = digit_out;
  assign bus.digit_valid  = digit_valid;
  assign bus.update_pulse = update_pulse;
  assign bus.reject_pulse = reject_pulse;
  assign bus.fsm_state    = state;

`ifdef SEVEN_SEG_EN
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  // Follows the published registers, so it lags digit_out by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      seg_n <= 7'h7F;
    else
      seg_n <= digit_valid ? seg_decode(digit_out) : 7'h7F;
  end
`endif

endmodule
